// File: rtl/i2s_source_tx_if.sv
// rtl/i2s_source_tx_if.sv - stereo sample handshake between a PCM producer and the I2S transmitter
interface i2s_source_tx_if;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] l_data;
  logic [23:0] r_data;

  modport master (output s_valid, output l_data, output r_data, input s_ready);
  modport slave  (input s_valid, input l_data, input r_data, output s_ready);
endinterface

// File: rtl/i2s_source_tx.sv
// rtl/i2s_source_tx.sv - I2S transmitter: 24-bit L/R in 64-bclk frames, one-entry input buffer
module i2s_source_tx (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [7:0]            bclk_div,
  i2s_source_tx_if.slave        s,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  frame_start,
  output logic                  underrun
);

  logic        run_q;
  logic [7:0]  div_lat;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic        buf_full;
  logic [23:0] buf_l;
  logic [23:0] buf_r;
  logic [23:0] sh_l;
  logic [23:0] sh_r;

  logic [7:0]  div_eff;
  logic        div_hit;
  logic        fall;
  logic [5:0]  k_next;
  logic        boundary;
  logic        accept;

  // On the first running cycle the divider register is still being loaded, so use the port.
  assign div_eff  = run_q ? div_lat : bclk_div;
  assign div_hit  = (div_cnt == div_eff);
  assign fall     = div_hit && bclk;
  assign k_next   = bit_cnt + 6'd1;
  assign boundary = fall && (k_next == 6'd0);
  assign accept   = s.s_valid && s.s_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      div_lat     <= 8'd0;
      div_cnt     <= 8'd0;
      bit_cnt     <= 6'd63;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      s.s_ready   <= 1'b0;
      buf_full    <= 1'b0;
      buf_l       <= 24'd0;
      buf_r       <= 24'd0;
      sh_l        <= 24'd0;
      sh_r        <= 24'd0;
    end else if (!run) begin
      run_q       <= 1'b0;
      div_cnt     <= 8'd0;
      bit_cnt     <= 6'd63;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      s.s_ready   <= 1'b0;
      buf_full    <= 1'b0;
      sh_l        <= 24'd0;
      sh_r        <= 24'd0;
    end else begin
      run_q       <= 1'b1;
      if (!run_q) begin
        div_lat <= bclk_div;
      end
      frame_start <= boundary;
      // Ready reopens only the cycle after a drain, and drops right after an accept.
      s.s_ready   <= !buf_full && !accept;

      if (div_hit) begin
        div_cnt <= 8'd0;
        bclk    <= !bclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end

      if (fall) begin
        bit_cnt <= k_next;
        lrclk   <= k_next[5];
        if (boundary) begin
          sh_l  <= buf_full ? buf_l : 24'd0;
          sh_r  <= buf_full ? buf_r : 24'd0;
          sdata <= 1'b0;
          if (!buf_full) begin
            underrun <= 1'b1;
          end
        end else if (k_next >= 6'd1 && k_next <= 6'd24) begin
          sdata <= sh_l[23];
          sh_l  <= {sh_l[22:0], 1'b0};
        end else if (k_next >= 6'd33 && k_next <= 6'd56) begin
          sdata <= sh_r[23];
          sh_r  <= {sh_r[22:0], 1'b0};
        end else begin
          sdata <= 1'b0;
        end
      end

      // A same-cycle accept wins: the drain already took the old contents above.
      if (accept) begin
        buf_full <= 1'b1;
        buf_l    <= s.l_data;
        buf_r    <= s.r_data;
      end else if (boundary) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_source_tx.sv
// tb/tb_i2s_source_tx.sv - randomized and directed bench for i2s_source_tx against a frame-level model
module tb_i2s_source_tx;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] bclk_div = 8'd0;
  logic       bclk, lrclk, sdata, frame_start, underrun;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;

  i2s_source_tx_if sif ();

  i2s_source_tx dut (
    .clk(clk), .reset_n(reset_n), .run(run), .bclk_div(bclk_div), .s(sif),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Model: outputs follow from the number of running clk edges n and the half-period D.
  bit        m_on = 0, m_acc = 0, m_full = 0, m_old_full;
  int        m_n = 0, m_d = 1, m_k;
  bit [23:0] m_buf_l, m_buf_r, m_cur_l, m_cur_r;
  bit        e_bclk = 0, e_lrclk = 0, e_sdata = 0, e_fs = 0, e_und = 0, e_rdy = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || !run) begin
      m_on = 0; m_n = 0; m_acc = 0; m_full = 0; m_cur_l = 0; m_cur_r = 0;
      e_bclk = 0; e_lrclk = 0; e_sdata = 0; e_fs = 0; e_und = 0; e_rdy = 0;
    end else begin
      if (!m_on) begin m_d = int'(bclk_div) + 1; m_on = 1; end
      m_old_full = m_full;
      m_acc = sif.s_valid && e_rdy;
      m_n++;
      e_bclk = ((m_n / m_d) % 2) == 1;
      e_fs = 0;
      if (m_n % (2 * m_d) == 0) begin
        m_k = ((m_n / (2 * m_d)) - 1) % 64;
        if (m_k == 0) begin
          e_fs = 1;
          if (m_full) begin m_cur_l = m_buf_l; m_cur_r = m_buf_r; m_full = 0; end
          else begin m_cur_l = 0; m_cur_r = 0; e_und = 1; end
        end
        e_lrclk = (m_k >= 32);
        if (m_k >= 1 && m_k <= 24) e_sdata = m_cur_l[24 - m_k];
        else if (m_k >= 33 && m_k <= 56) e_sdata = m_cur_r[56 - m_k];
        else e_sdata = 0;
      end
      e_rdy = !m_old_full && !m_acc;
      if (m_acc) begin m_full = 1; m_buf_l = sif.l_data; m_buf_r = sif.r_data; end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("bclk", bclk, e_bclk);
      check("lrclk", lrclk, e_lrclk);
      check("sdata", sdata, e_sdata);
      check("frame_start", frame_start, e_fs);
      check("underrun", underrun, e_und);
      check("s_ready", sif.s_ready, e_rdy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (frame_start) begin t = cyc; return; end
    end
    check("frame_start_timeout", 1, 0);
  endtask

  // Collects the 64 bits seen at bclk rising edges after a frame_start; index 0 is the MSB.
  task automatic capture_frame(output logic [63:0] sd, output logic [63:0] lr);
    int idx = 0;
    logic prev = bclk;
    sd = 0; lr = 0;
    for (int i = 0; i < 40000 && idx < 64; i++) begin
      tick();
      if (bclk && !prev) begin sd[63 - idx] = sdata; lr[63 - idx] = lrclk; idx++; end
      prev = bclk;
    end
    if (idx < 64) check("capture_timeout", 1, 0);
  endtask

  task automatic stop_run();
    run = 1'b0;
    tick();
  endtask

  logic [63:0] sd, lr;
  int t1, t2, c, nfs, nacc, nfall, cnt;
  logic prev;

  initial begin
    sif.s_valid = 0; sif.l_data = 0; sif.r_data = 0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk_en = 1'b1;
    check("reset_bclk", bclk, 0);
    check("reset_s_ready", sif.s_ready, 0);
    check("reset_underrun", underrun, 0);
    repeat (5) tick();
    check("idle_bclk", bclk, 0);

    // Normal frame at bclk_div=1
    bclk_div = 8'd1; sif.s_valid = 1; sif.l_data = 24'hA5A5A5; sif.r_data = 24'h123456;
    run = 1'b1;
    for (int i = 0; i < 20 && !m_acc; i++) tick();
    sif.s_valid = 0;
    wait_fs(50, t1);
    capture_frame(sd, lr);
    check("normal_left", sd[62:39], 24'hA5A5A5);
    check("normal_right", sd[30:7], 24'h123456);
    check("normal_pad", sd & 64'h8000007F8000007F, 0);
    check("normal_lrclk", lr, 64'h00000000FFFFFFFF);
    check("normal_underrun", underrun, 0);
    wait_fs(300, t2);
    check("frame_len_div1", t2 - t1, 256);
    stop_run();

    // Underrun with no sample offered
    bclk_div = 8'd0; run = 1'b1;
    wait_fs(20, t1);
    check("underrun_set", underrun, 1);
    capture_frame(sd, lr);
    check("underrun_silent", sd, 0);
    stop_run();
    check("underrun_cleared", underrun, 0);

    // Accept lands on the boundary edge: silent frame, sample kept for the next frame
    sif.s_valid = 1; sif.l_data = 24'h111111; sif.r_data = 24'h222222; run = 1'b1;
    wait_fs(20, t1);
    sif.s_valid = 0;
    check("simul_accept", m_acc, 1);
    check("simul_ready_low", sif.s_ready, 0);
    capture_frame(sd, lr);
    check("simul_first_silent", sd, 0);
    check("simul_ready_held", sif.s_ready, 0);
    wait_fs(200, t2);
    capture_frame(sd, lr);
    check("simul_left", sd[62:39], 24'h111111);
    check("simul_right", sd[30:7], 24'h222222);
    stop_run();

    // Backpressure: a stream of incrementing samples, one accept per frame
    bclk_div = 8'd1; cnt = 1; sif.s_valid = 1;
    sif.l_data = 24'(cnt); sif.r_data = 24'(cnt + 24'h800000);
    run = 1'b1; nfs = 0; nacc = 0;
    for (int i = 0; i < 3000 && nfs < 9; i++) begin
      tick();
      if (m_acc) begin cnt++; sif.l_data = 24'(cnt); sif.r_data = 24'(cnt + 24'h800000); end
      if (frame_start) nfs++;
      if (nfs >= 1 && nfs < 9 && sif.s_valid && sif.s_ready) nacc++;
    end
    check("bp_accepts_8_frames", nacc, 8);
    check("bp_no_underrun", underrun, 0);
    sif.s_valid = 0;
    stop_run();

    // Abort at bit_cnt=40, then restart timing
    run = 1'b1;
    wait_fs(20, t1);
    nfall = 0; prev = bclk;
    for (int i = 0; i < 400 && nfall < 40; i++) begin
      tick();
      if (prev && !bclk) nfall++;
      prev = bclk;
    end
    check("abort_lrclk_before", lrclk, 1);
    run = 1'b0;
    tick();
    check("abort_outputs", {bclk, lrclk, sdata}, 0);
    run = 1'b1; c = 0;
    for (int i = 0; i < 10 && !bclk; i++) begin tick(); c++; end
    check("restart_first_rise", c, 2);
    for (int i = 0; i < 10 && !frame_start; i++) begin tick(); c++; end
    check("restart_first_boundary", c, 4);

    // Asynchronous reset mid-frame
    repeat (37) tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {bclk, lrclk, sdata, frame_start, underrun, sif.s_ready}, 0);
    run = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Divider extremes and mid-run divider change
    bclk_div = 8'd0; run = 1'b1;
    wait_fs(20, t1); wait_fs(300, t2);
    check("frame_len_div0", t2 - t1, 128);
    stop_run();
    bclk_div = 8'd255; run = 1'b1;
    wait_fs(600, t1); wait_fs(33000, t2);
    check("frame_len_div255", t2 - t1, 32768);
    stop_run();
    bclk_div = 8'd3; run = 1'b1;
    tick();
    bclk_div = 8'd7;
    wait_fs(40, t1); wait_fs(1200, t2);
    check("frame_len_div_locked", t2 - t1, 512);
    stop_run();

    // Randomized traffic, checked cycle by cycle against the model
    bclk_div = 8'($urandom_range(0, 3)); run = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (m_acc) begin sif.l_data = 24'($urandom); sif.r_data = 24'($urandom); end
      if ($urandom_range(0, 3) == 0) sif.s_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) bclk_div = 8'($urandom_range(0, 3));
      if (!run) run = 1'b1;
      else if ($urandom_range(0, 2999) == 0) run = 1'b0;
    end
    run = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
